// File: rtl/iot_filter_if.sv
// Host-side bundle of the IoT filter front-end: beat input, function select and sequencer outputs.
interface iot_filter_if #(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_WORD  = 16,
    parameter int WORDS_PER_ROUND = 8,
    parameter int NUM_FN          = 7
);
    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int CYC_W  = $clog2(BYTES_PER_WORD);
    localparam int DAT_W  = $clog2(WORDS_PER_ROUND);
    localparam int SEL_W  = $clog2(NUM_FN + 1);

    logic              in_en;
    logic [BYTE_W-1:0] iot_in;
    logic [SEL_W-1:0]  fn_sel;
    logic              busy;
    logic [WORD_W-1:0] data;
    logic [CYC_W-1:0]  cnt_cycle;
    logic [DAT_W-1:0]  cnt_data;
    logic [NUM_FN-1:0] fn_en;
    logic              valid;

    modport master (
        output in_en, iot_in, fn_sel,
        input  busy, data, cnt_cycle, cnt_data, fn_en, valid
    );

    modport slave (
        input  in_en, iot_in, fn_sel,
        output busy, data, cnt_cycle, cnt_data, fn_en, valid
    );
endinterface

// File: rtl/iot_filter_ctrl.sv
// Front-end sequencer: assembles beats into words, counts slots, drives fn_en/valid/busy.
// Optional FN_SEL_LOCK_EN: sample fn_sel only on the first beat of a round and hold it.
module iot_filter_ctrl #(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_WORD  = 16,
    parameter int WORDS_PER_ROUND = 8,
    parameter int NUM_FN          = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    iot_filter_if.slave  bus
);
    localparam int WORD_W  = BYTE_W * BYTES_PER_WORD;
    localparam int SHIFT_W = WORD_W - BYTE_W;
    localparam int CYC_W   = $clog2(BYTES_PER_WORD);
    localparam int DAT_W   = $clog2(WORDS_PER_ROUND);
    localparam int SEL_W   = $clog2(NUM_FN + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BYTES_PER_WORD - 1);
    localparam logic [DAT_W-1:0] DAT_LAST = DAT_W'(WORDS_PER_ROUND - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [NUM_FN-1:0]  fn_en_q, fn_en_d, fn_dec;
    logic               last_slot;
    logic               accept;
    logic               round_start;

    assign last_slot = (cyc_q == CYC_LAST) && (dat_q == DAT_LAST);

    always_comb begin
        fn_dec = '0;
        for (int k = 0; k < NUM_FN; k++) begin
            if (bus.fn_sel == SEL_W'(k + 1)) fn_dec[k] = 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cyc_d       = cyc_q;
        dat_d       = dat_q;
        accept      = 1'b0;
        round_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_en) begin
                    state_d     = RUN;
                    accept      = 1'b1;
                    round_start = 1'b1;
                end
            end
            RUN: begin
                if (bus.in_en) begin
                    accept = 1'b1;
                    if (last_slot) state_d = DONE;
                end
            end
            DONE: begin
                // The beat offered here is dropped; it only restarts the round.
                state_d     = bus.in_en ? RUN : IDLE;
                round_start = bus.in_en;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], bus.iot_in};
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                dat_d = (dat_q == DAT_LAST) ? '0 : dat_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end

`ifdef FN_SEL_LOCK_EN
        fn_en_d = round_start ? fn_dec : fn_en_q;
`else
        fn_en_d = fn_dec;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cyc_q   <= '0;
            dat_q   <= '0;
            fn_en_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            dat_q   <= dat_d;
            fn_en_q <= fn_en_d;
        end
    end

    assign bus.data      = {shift_q, bus.iot_in};
    assign bus.cnt_cycle = cyc_q;
    assign bus.cnt_data  = dat_q;
    assign bus.fn_en     = fn_en_q;
    assign bus.busy      = (state_q == DONE);
    assign bus.valid     = (state_q == RUN) && bus.in_en && last_slot;
endmodule

// File: tb/tb_iot_filter_ctrl.sv
// Self-checking bench for iot_filter_ctrl against a beat-count reference model.
module tb_iot_filter_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   vcount;

    iot_filter_if bus ();

    iot_filter_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted beats in the round, post-round hold, byte history.
    int         acc;
    bit         hold;
    logic [7:0] hist[$];
    logic [6:0] exp_fn;
    logic [7:0] last_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [2:0] s);
        if (s == 3'd0) return 7'd0;
        return 7'd1 << (s - 3'd1);
    endfunction

    function automatic logic [127:0] exp_data(input logic [7:0] b);
        logic [127:0] d;
        d = '0;
        foreach (hist[i]) d = {d[119:0], hist[i]};
        return {d[119:0], b};
    endfunction

    task automatic model_reset();
        acc    = 0;
        hold   = 1'b0;
        exp_fn = '0;
        hist.delete();
    endtask

    task automatic step(input bit en, input logic [7:0] b, input logic [2:0] sel);
        @(negedge clk);
        bus.in_en  = en;
        bus.iot_in = b;
        bus.fn_sel = sel;
        last_b     = b;
        #1;
        check("cnt_cycle", bus.cnt_cycle, 128'(acc % 16));
        check("cnt_data", bus.cnt_data, 128'(acc / 16));
        check("busy", bus.busy, 128'(hold));
        check("valid", bus.valid, 128'(!hold && en && acc == 127));
        check("data", bus.data, exp_data(b));
        check("fn_en", bus.fn_en, exp_fn);
        if (bus.valid === 1'b1) vcount++;
`ifdef FN_SEL_LOCK_EN
        if (en && (hold || acc == 0)) exp_fn = dec(sel);
`else
        exp_fn = dec(sel);
`endif
        if (hold) begin
            hold = 1'b0;
        end else if (en) begin
            hist.push_back(b);
            if (hist.size() > 15) void'(hist.pop_front());
            acc++;
            if (acc == 128) begin
                acc  = 0;
                hold = 1'b1;
            end
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cnt_cycle", bus.cnt_cycle, 128'd0);
        check("rst_cnt_data", bus.cnt_data, 128'd0);
        check("rst_busy", bus.busy, 128'd0);
        check("rst_valid", bus.valid, 128'd0);
        check("rst_fn_en", bus.fn_en, 128'd0);
        check("rst_data", bus.data, {120'd0, last_b});
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int v0;
        logic [2:0] rsel;
        checks     = 0;
        errors     = 0;
        vcount     = 0;
        last_b     = 8'h00;
        rst_n      = 1'b0;
        bus.in_en  = 1'b0;
        bus.iot_in = 8'h00;
        bus.fn_sel = 3'd0;
        model_reset();
        #1;
        check("init_busy", bus.busy, 128'd0);
        check("init_valid", bus.valid, 128'd0);
        check("init_cnt", {bus.cnt_data, bus.cnt_cycle}, 128'd0);
        check("init_fn_en", bus.fn_en, 128'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Straight round 0x00..0x7F, fn_sel=1
        v0 = vcount;
        for (int i = 0; i < 128; i++) step(1'b1, 8'(i), 3'd1);
        step(1'b0, 8'h00, 3'd1);
        step(1'b0, 8'h00, 3'd1);
        check("round1_valid_pulses", 128'(vcount - v0), 128'd1);
        check("round1_fn_en", bus.fn_en, 128'b0000001);

        // Stall for 3 cycles at beat 40
        for (int i = 0; i < 128; i++) begin
            if (i == 40) repeat (3) step(1'b0, 8'hEE, 3'd1);
            step(1'b1, 8'(i), 3'd1);
        end
        step(1'b0, 8'h00, 3'd1);

        // Back-to-back rounds with in_en held through DONE
        v0 = vcount;
        for (int i = 0; i < 128; i++) step(1'b1, 8'($urandom), 3'd1);
        step(1'b1, 8'hA5, 3'd1);
        for (int i = 0; i < 128; i++) step(1'b1, 8'($urandom), 3'd1);
        step(1'b0, 8'h00, 3'd1);
        step(1'b0, 8'h00, 3'd1);
        check("b2b_valid_pulses", 128'(vcount - v0), 128'd2);

        // fn_sel 1 -> 3 at beat 50
        for (int i = 0; i < 128; i++) step(1'b1, 8'($urandom), (i < 50) ? 3'd1 : 3'd3);
        step(1'b0, 8'h00, 3'd3);
        step(1'b0, 8'h00, 3'd3);
        step(1'b1, 8'h11, 3'd3);
        step(1'b0, 8'h00, 3'd3);

        // Asynchronous reset at beat 70
        for (int i = 0; i < 70; i++) step(1'b1, 8'($urandom), 3'd2);
        async_reset();
        for (int i = 0; i < 128; i++) step(1'b1, 8'($urandom), 3'd2);
        step(1'b0, 8'h00, 3'd2);

        // fn_sel=0 round
        for (int i = 0; i < 128; i++) step(1'b1, 8'($urandom), 3'd0);
        step(1'b0, 8'h00, 3'd0);
        step(1'b0, 8'h00, 3'd0);

        // Random traffic with gaps and occasional select changes
        rsel = 3'd4;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 31) == 0) rsel = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, 8'($urandom), rsel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
